// File: rtl/alu_exec_stage.sv
// Execute stage wrapped around an external combinational alu: decodes one instruction,
// reads operands from a local register file, and retires the result and flags.
module alu_exec_stage #(
  parameter int BW   = 16,
  parameter int NREG = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [3:0]                instr_op,
  input  logic [$clog2(NREG)-1:0]   instr_rd,
  input  logic [$clog2(NREG)-1:0]   instr_rs1,
  input  logic [$clog2(NREG)-1:0]   instr_rs2,
  input  logic [BW-1:0]             instr_imm,
  output logic [BW-1:0]             alu_a,
  output logic [BW-1:0]             alu_b,
  output logic [3:0]                alu_opcode,
  input  logic [BW-1:0]             alu_out,
  input  logic [2:0]                alu_flags,
  output logic                      done,
  output logic                      err,
  output logic [BW-1:0]             result,
  output logic [2:0]                flags,
  input  logic [$clog2(NREG)-1:0]   dbg_addr,
  output logic [BW-1:0]             dbg_data
);

  localparam int AW = $clog2(NREG);
  localparam logic [3:0] OP_LDI = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic [AW-1:0]     rd_q, rs1_q, rs2_q;
  logic [BW-1:0]     imm_q, res_q;
  logic [2:0]        flg_q, flags_q;
  logic              err_q;
  logic [BW-1:0]     regs [NREG];

  logic              is_alu, is_ldi;

  assign is_ldi = (op_q == OP_LDI);
  assign is_alu = (op_q[3] == 1'b0) && !is_ldi;

  assign instr_ready = (state == IDLE);
  assign done        = (state == WB);
  assign err         = (state == WB) && err_q;
  assign result      = res_q;
  assign flags       = flags_q;
  assign dbg_data    = regs[dbg_addr];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (instr_valid) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are presented only while an alu op is in EXEC; otherwise the alu sees zeros.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    if (state == EXEC && is_alu) begin
      alu_a      = regs[rs1_q];
      alu_b      = regs[rs2_q];
      alu_opcode = op_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            imm_q <= instr_imm;
          end
        end
        EXEC: begin
          if (is_alu) begin
            res_q <= alu_out;
            flg_q <= alu_flags;
            err_q <= 1'b0;
          end else if (is_ldi) begin
            res_q <= imm_q;
            flg_q <= {1'b0, imm_q[BW-1], imm_q == '0};
            err_q <= 1'b0;
          end else begin
            res_q <= '0;
            flg_q <= '0;
            err_q <= 1'b1;
          end
        end
        WB: begin
          // r0 is hardwired to zero, but flags still retire for rd=0.
          if (!err_q) begin
            if (rd_q != '0) regs[rd_q] <= res_q;
            flags_q <= flg_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: a stand-in alu plus a register-file/flags model.
module tb_alu_exec_stage;

  localparam int BW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [BW-1:0] instr_imm = '0;
  logic [BW-1:0] alu_a, alu_b, alu_out;
  logic [3:0]    alu_opcode;
  logic [2:0]    alu_flags;
  logic          done, err;
  logic [BW-1:0] result, dbg_data;
  logic [2:0]    flags;
  logic [AW-1:0] dbg_addr = '0;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] mregs [NREG];
  logic [2:0]    mflags;

  always #5 clk = ~clk;

  alu_exec_stage #(.BW(BW), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .done(done), .err(err), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural alu: returns {ovf, neg, zero, result} using signed integer arithmetic.
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, s;
    logic [15:0] r;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ovf = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; r = s[15:0]; ovf = (s > 32767) || (s < -32768); end
      4'd1: begin s = sa - sb; r = s[15:0]; ovf = (s > 32767) || (s < -32768); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << 1;
      4'd6: r = a >> 1;
      default: r = 16'd0;
    endcase
    return {ovf, r[15], r == 16'd0, r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = '0;
    mflags = '0;
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1;
      check($sformatf("dbg_r%0d", i), 32'(dbg_data), 32'(mregs[i]));
    end
  endtask

  task automatic run(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                     input logic [15:0] imm, input bit hold);
    logic [15:0] a, b, eres;
    logic [2:0]  eflg;
    logic [18:0] ar;
    bit ill, alu_op;
    ill    = op[3];
    alu_op = !ill && (op != 4'd7);
    a = mregs[rs1];
    b = mregs[rs2];
    if (ill) begin
      eres = '0; eflg = mflags;
    end else if (!alu_op) begin
      eres = imm; eflg = {1'b0, imm[15], imm == 16'd0};
    end else begin
      ar = alu_fn(op, a, b);
      eres = ar[15:0]; eflg = ar[18:16];
    end
    @(negedge clk);
    check("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_op  = op;
    instr_rd  = AW'(rd);
    instr_rs1 = AW'(rs1);
    instr_rs2 = AW'(rs2);
    instr_imm = imm;
    @(posedge clk); #1;
    check("ready_exec", 32'(instr_ready), 32'd0);
    check("done_exec", 32'(done), 32'd0);
    check("alu_a", 32'(alu_a), alu_op ? 32'(a) : 32'd0);
    check("alu_b", 32'(alu_b), alu_op ? 32'(b) : 32'd0);
    check("alu_opcode", 32'(alu_opcode), alu_op ? 32'(op) : 32'd0);
    if (!hold) instr_valid = 1'b0;
    @(posedge clk); #1;
    check("done_wb", 32'(done), 32'd1);
    check("err_wb", 32'(err), 32'(ill));
    check("result_wb", 32'(result), 32'(eres));
    check("alu_a_wb", 32'(alu_a), 32'd0);
    check("ready_wb", 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (!ill) begin
      if (rd != 0) mregs[rd] = eres;
      mflags = eflg;
    end
    check("done_after", 32'(done), 32'd0);
    check("ready_after", 32'(instr_ready), 32'd1);
    check("flags", 32'(flags), 32'(mflags));
    sweep_regs();
  endtask

  initial begin
    logic [3:0] op;
    model_reset();
    #12 rst_n = 1'b1;

    // 1: preload, then reset mid-stream
    run(4'd7, 3, 0, 0, 16'h1234, 1'b0);
    run(4'd7, 4, 0, 0, 16'h8000, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    sweep_regs();
    @(negedge clk) rst_n = 1'b1;

    // 2: no-overflow add
    run(4'd7, 1, 0, 0, 16'd10000, 1'b0);
    run(4'd7, 2, 0, 0, 16'd20000, 1'b0);
    run(4'd0, 3, 1, 2, 16'hFFFF, 1'b0);
    check("t2_flags", 32'(flags), 32'b000);
    check("t2_r3", 32'(mregs[3]), 32'd30000);

    // 3: signed overflow into negative
    run(4'd7, 1, 0, 0, 16'd30000, 1'b0);
    run(4'd7, 2, 0, 0, 16'd10000, 1'b0);
    run(4'd0, 3, 1, 2, 16'd0, 1'b0);
    check("t3_flags", 32'(flags), 32'b110);
    check("t3_r3", 32'(mregs[3]), 32'h9C40);

    // 4: write to r0 is dropped but flags retire
    run(4'd1, 0, 1, 1, 16'd0, 1'b0);
    check("t4_flags", 32'(flags), 32'b001);
    dbg_addr = '0; #1;
    check("t4_r0", 32'(dbg_data), 32'd0);

    // 5: illegal op with valid held through EXEC/WB
    run(4'd7, 5, 0, 0, 16'd7, 1'b0);
    run(4'b1010, 5, 1, 2, 16'h00FF, 1'b1);
    check("t5_flags", 32'(flags), 32'b000);
    dbg_addr = 3'd5; #1;
    check("t5_r5", 32'(dbg_data), 32'd7);

    // randomized mix including illegal ops and LDI zero
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(8, 15));
      else op = 4'($urandom_range(0, 7));
      run(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // 6: reset during EXEC aborts the instruction
    model_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run(4'd7, 1, 0, 0, 16'd5, 1'b0);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd0; instr_rd = 3'd6; instr_rs1 = 3'd1; instr_rs2 = 3'd1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("t6_exec", 32'(instr_ready), 32'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_ready", 32'(instr_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("t6_done2", 32'(done), 32'd0);
    check("t6_flags", 32'(flags), 32'd0);
    sweep_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
